// File: rtl/vga_tile_compositor.sv
// vga_tile_compositor: two-stage tile map + sprite overlay pixel compositor with collision flags
module vga_tile_compositor #(
  parameter int TILE_SIZE = 40,
  parameter int MAP_COLS = 17,
  parameter int MAP_ROWS = 12,
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 43,
  parameter int COORD_W = 11,
  localparam int MAP_W = MAP_COLS * TILE_SIZE,
  localparam int MAP_H = MAP_ROWS * TILE_SIZE,
  localparam int SL_W = $clog2(SPRITE_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             row,
  input  logic [COORD_W-1:0]             col,
  input  logic [COORD_W-1:0]             scroll_x,
  input  logic                           map_we,
  input  logic [7:0]                     map_row,
  input  logic [7:0]                     map_col,
  input  logic [1:0]                     map_type,
  input  logic [NUM_SPRITES-1:0]         spr_en,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
  output logic [2:0]                     spr_id,
  output logic [SL_W-1:0]                spr_lx,
  output logic [SL_W-1:0]                spr_ly,
  input  logic [11:0]                    spr_rgb,
  input  logic                           spr_opaque,
  output logic [3:0]                     red,
  output logic [3:0]                     green,
  output logic [3:0]                     blue,
  output logic                           out_valid,
  output logic [NUM_SPRITES-1:0]         collide
);
  localparam int RW = $clog2(MAP_ROWS);
  localparam int CW = $clog2(MAP_COLS);
  localparam logic [COORD_W:0] MAP_W_C = (COORD_W+1)'(MAP_W);
  localparam logic [COORD_W:0] MAP_H_C = (COORD_W+1)'(MAP_H);
  localparam logic [COORD_W:0] TS_C = (COORD_W+1)'(TILE_SIZE);
  localparam logic [COORD_W:0] SS_C = (COORD_W+1)'(SPRITE_SIZE - 1);
  localparam logic [7:0] MR_C = 8'(MAP_ROWS);
  localparam logic [7:0] MC_C = 8'(MAP_COLS);
  logic [1:0] map_q [MAP_ROWS][MAP_COLS];
  logic [COORD_W-1:0] scroll_q;
  logic [COORD_W:0] cx, cy, wx_sum, wx, sx, sy;
  logic first_pix, off_map, any_hit;
  logic [RW-1:0] trow;
  logic [CW-1:0] tcol;
  logic [1:0] tile, tile1;
  logic [2:0] win;
  logic [SL_W-1:0] lx, ly;
  logic v1, first1, off1, hit1;
  logic [11:0] bg, pix;
  logic [NUM_SPRITES-1:0] hit_mask;
  always_comb begin
    cx = {1'b0, col};
    cy = {1'b0, row};
    first_pix = pix_valid && row == '0 && col == '0;
    wx_sum = cx + {1'b0, scroll_q};
    wx = wx_sum >= MAP_W_C ? wx_sum - MAP_W_C : wx_sum;
    off_map = cy >= MAP_H_C || cx >= MAP_W_C;
    trow = off_map ? '0 : RW'(cy / TS_C);
    tcol = off_map ? '0 : CW'(wx / TS_C);
    tile = map_q[trow][tcol];
    any_hit = 1'b0;
    win = '0;
    lx = '0;
    ly = '0;
    sx = '0;
    sy = '0;
    // Descending scan so the lowest-index hit is the last assignment and wins
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      sx = {1'b0, spr_x[i*COORD_W +: COORD_W]};
      sy = {1'b0, spr_y[i*COORD_W +: COORD_W]};
      if (spr_en[i] && cx >= sx && cx <= sx + SS_C && cy >= sy && cy <= sy + SS_C) begin
        any_hit = 1'b1;
        win = 3'(i);
        lx = SL_W'(cx - sx);
        ly = SL_W'(cy - sy);
      end
    end
  end
  always_comb begin
    bg = off1 ? 12'h000 : tile1 == 2'd0 ? 12'hf00 : tile1 == 2'd1 ? 12'h09f : tile1 == 2'd2 ? 12'h843 : 12'h0f2;
    pix = hit1 && spr_opaque ? spr_rgb : bg;
    hit_mask = v1 && hit1 && spr_opaque && tile1[1] && !off1 ? NUM_SPRITES'(1) << spr_id : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < MAP_ROWS; r++)
        for (int c = 0; c < MAP_COLS; c++)
          map_q[r][c] <= (r == 0 || r == MAP_ROWS - 1) ? 2'd0 : r == MAP_ROWS - 2 ? 2'd3 : 2'd1;
    end else if (map_we && map_row < MR_C && map_col < MC_C) begin
      map_q[RW'(map_row)][CW'(map_col)] <= map_type;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scroll_q <= '0;
      v1 <= 1'b0;
      first1 <= 1'b0;
      off1 <= 1'b0;
      hit1 <= 1'b0;
      tile1 <= '0;
      spr_id <= '0;
      spr_lx <= '0;
      spr_ly <= '0;
      out_valid <= 1'b0;
      {red, green, blue} <= '0;
      collide <= '0;
    end else begin
      if (first_pix && {1'b0, scroll_x} < MAP_W_C) scroll_q <= scroll_x;
      v1 <= pix_valid;
      first1 <= first_pix;
      off1 <= off_map;
      hit1 <= any_hit;
      tile1 <= tile;
      spr_id <= win;
      spr_lx <= lx;
      spr_ly <= ly;
      out_valid <= v1;
      {red, green, blue} <= v1 ? pix : 12'h000;
      if (v1) collide <= (first1 ? '0 : collide) | hit_mask;
    end
  end
endmodule

// File: tb/tb_vga_tile_compositor.sv
// tb_vga_tile_compositor: directed vectors and corner sequences for vga_tile_compositor
module tb_vga_tile_compositor;
  logic clk = 0, reset = 1, pix_valid = 0, map_we = 0, op_en = 1;
  logic [10:0] row = 0, col = 0, scroll_x = 0;
  logic [7:0] map_row = 0, map_col = 0;
  logic [1:0] map_type = 0;
  logic [3:0] spr_en = 0, collide;
  logic [43:0] spr_x = 0, spr_y = 0;
  logic [2:0] spr_id;
  logic [5:0] spr_lx, spr_ly;
  logic [11:0] spr_rgb;
  logic spr_opaque, out_valid;
  logic [3:0] red, green, blue;
  int checks = 0, errors = 0;
  int m_ov, m_id, m_lx, m_ly;
  typedef struct { int r; int c; logic [11:0] rgb; } vec_t;
  vec_t tv [9];
  always #5 clk = ~clk;
  assign spr_rgb = {1'b0, spr_id, spr_lx[3:0], spr_ly[3:0]};
  assign spr_opaque = op_en;
  vga_tile_compositor dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .row(row), .col(col), .scroll_x(scroll_x),
    .map_we(map_we), .map_row(map_row), .map_col(map_col), .map_type(map_type),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_id(spr_id), .spr_lx(spr_lx), .spr_ly(spr_ly),
    .spr_rgb(spr_rgb), .spr_opaque(spr_opaque), .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .collide(collide)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic px(input string nm, input int r, input int c, input logic [11:0] exp);
    @(negedge clk);
    pix_valid = 1; row = 11'(r); col = 11'(c);
    @(negedge clk);
    pix_valid = 0;
    m_ov = int'(out_valid); m_id = int'(spr_id); m_lx = int'(spr_lx); m_ly = int'(spr_ly);
    @(negedge clk);
    chk({nm, "_rgb"}, int'({red, green, blue}), int'(exp));
    chk({nm, "_ov"}, int'(out_valid), 1);
  endtask
  initial begin
    tv[0] = '{0, 0, 12'hf00};
    tv[1] = '{400, 10, 12'h0f2};
    tv[2] = '{200, 100, 12'h09f};
    tv[3] = '{479, 679, 12'hf00};
    tv[4] = '{439, 0, 12'h0f2};
    tv[5] = '{40, 0, 12'h09f};
    tv[6] = '{480, 0, 12'h000};
    tv[7] = '{0, 680, 12'h000};
    tv[8] = '{0, 679, 12'hf00};
    #2;
    chk("rst_rgb", int'({red, green, blue}), 0);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_collide", int'(collide), 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    px("first", 0, 0, 12'hf00);
    chk("first_latency", m_ov, 0);
    for (int i = 0; i < 9; i++) px($sformatf("vec%0d", i), tv[i].r, tv[i].c, tv[i].rgb);
    @(negedge clk);
    chk("bubble_ov", int'(out_valid), 0);
    chk("bubble_rgb", int'({red, green, blue}), 0);
    // write BLK to (5,2) while the same tile is being read
    @(negedge clk);
    pix_valid = 1; row = 200; col = 80; map_we = 1; map_row = 5; map_col = 2; map_type = 2;
    @(negedge clk);
    map_we = 0;
    @(negedge clk);
    pix_valid = 0;
    chk("bypass_old", int'({red, green, blue}), 12'h09f);
    @(negedge clk);
    chk("bypass_new", int'({red, green, blue}), 12'h843);
    @(negedge clk);
    map_we = 1; map_row = 12; map_col = 0; map_type = 2;
    @(negedge clk);
    map_we = 1; map_row = 5; map_col = 17; map_type = 3;
    @(negedge clk);
    map_we = 0;
    px("oob_row11", 440, 0, 12'hf00);
    px("oob_row10", 400, 0, 12'h0f2);
    px("oob_col16", 200, 660, 12'h09f);
    // scroll latch and wrap
    scroll_x = 660;
    px("scr_latch", 0, 0, 12'hf00);
    px("scr_wrap", 200, 20, 12'h09f);
    px("scr_blk", 200, 125, 12'h843);
    px("scr_sky", 200, 85, 12'h09f);
    scroll_x = 200;
    px("scr_mid", 200, 125, 12'h843);
    scroll_x = 700;
    px("scr_big_latch", 0, 0, 12'hf00);
    px("scr_big", 200, 125, 12'h843);
    scroll_x = 200;
    px("scr200_latch", 0, 0, 12'hf00);
    px("scr200", 200, 570, 12'h843);
    scroll_x = 0;
    px("scr0_latch", 0, 0, 12'hf00);
    // sprite priority and transparency
    spr_en = 4'b0110;
    spr_x[11 +: 11] = 90; spr_y[11 +: 11] = 95;
    spr_x[22 +: 11] = 100; spr_y[22 +: 11] = 100;
    px("spr_prio", 100, 100, 12'h1a5);
    chk("spr_prio_id", m_id, 1);
    chk("spr_prio_lx", m_lx, 10);
    chk("spr_prio_ly", m_ly, 5);
    op_en = 0;
    px("spr_transp", 100, 100, 12'h09f);
    op_en = 1;
    spr_en = 4'b0100;
    px("spr_edge_in", 100, 142, 12'h2a0);
    chk("spr_edge_in_id", m_id, 2);
    chk("spr_edge_in_lx", m_lx, 42);
    px("spr_edge_out", 100, 143, 12'h09f);
    chk("spr_edge_out_id", m_id, 0);
    chk("spr_edge_out_lx", m_lx, 0);
    // collision flags
    spr_en = 4'b0001;
    spr_x[0 +: 11] = 0; spr_y[0 +: 11] = 200;
    px("col_latch", 0, 0, 12'hf00);
    chk("col_clear0", int'(collide), 0);
    px("col_sky", 200, 5, 12'h050);
    chk("col_sky_flag", int'(collide), 0);
    spr_y[0 +: 11] = 400;
    px("col_gnd", 410, 5, 12'h05a);
    chk("col_gnd_flag", int'(collide), 1);
    px("col_hold", 100, 100, 12'h09f);
    chk("col_hold_flag", int'(collide), 1);
    px("col_next", 0, 0, 12'hf00);
    chk("col_next_flag", int'(collide), 0);
    px("col_gnd2", 410, 5, 12'h05a);
    chk("col_gnd2_flag", int'(collide), 1);
    // asynchronous reset between edges while streaming
    spr_en = 0;
    @(negedge clk);
    pix_valid = 1; row = 400; col = 10;
    @(negedge clk); @(negedge clk);
    chk("ar_pre_ov", int'(out_valid), 1);
    #2 reset = 1;
    #1;
    chk("ar_ov", int'(out_valid), 0);
    chk("ar_rgb", int'({red, green, blue}), 0);
    chk("ar_collide", int'(collide), 0);
    @(negedge clk);
    reset = 0; pix_valid = 0;
    px("ar_map", 200, 80, 12'h09f);
    chk("ar_latency", m_ov, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
